// File: rtl/grf_sb.sv
// General register file with a per-register pending-write scoreboard and write-through read bypass.
// Optional macro GRF_TRACE_EN: logs every committed write as "@pc: $reg <= data".
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [31:0]                pc,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pending,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_ready,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          wa,
  input  logic [DATA_W-1:0]          wd,
  output logic                       err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [CNT_W-1:0]  cnt  [DEPTH];
  logic              wr_en;
  logic              iss_acc;
  logic [DEPTH-1:0]  inc;
  logic [DEPTH-1:0]  dec;

  // Register 0 is excluded here, so its data and counter are never touched.
  assign wr_en     = we && (wa != '0);
  assign iss_ready = (cnt[iss_addr] != CNT_MAX) || (we && (wa == iss_addr));
  assign iss_acc   = iss_valid && iss_ready && (iss_addr != '0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
      assign inc[gi] = iss_acc && (iss_addr == ADDR_W'(gi));
      assign dec[gi] = wr_en && (wa == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      err <= 1'b0;
    end else begin
      if (wr_en) begin
        regs[wa] <= wd;
        if (cnt[wa] == '0) err <= 1'b1;
      end
      for (int r = 0; r < DEPTH; r++) begin
        if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + 1'b1;
        else if (dec[r] && !inc[r] && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_data[gi*DATA_W +: DATA_W] = (wr_en && (wa == a)) ? wd : regs[a];
      // Pending reflects the stored counter only; a same-cycle bypass does not hide it.
      assign rd_pending[gi] = (cnt[a] != '0);
    end
  endgenerate

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && wr_en) $display("@%h: $%d <= %h", pc, wa, wd);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule
